// File: rtl/mpsoc_wb_ext_arbiter_if.sv
// Wishbone bundle between NUM_MASTERS requesters, the arbiter and one external slave.
// The arbiter uses the slave modport; the master modport is the requester/slave-model side.
interface mpsoc_wb_ext_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0][31:0] m_adr_i;
    logic [NUM_MASTERS-1:0][31:0] m_dat_i;
    logic [NUM_MASTERS-1:0][3:0]  m_sel_i;
    logic [NUM_MASTERS-1:0][2:0]  m_cti_i;
    logic [NUM_MASTERS-1:0][1:0]  m_bte_i;
    logic [NUM_MASTERS-1:0]       m_cyc_i;
    logic [NUM_MASTERS-1:0]       m_stb_i;
    logic [NUM_MASTERS-1:0]       m_we_i;
    logic [NUM_MASTERS-1:0]       m_cab_i;
    logic [31:0]                  m_dat_o;
    logic [NUM_MASTERS-1:0]       m_ack_o;
    logic [NUM_MASTERS-1:0]       m_err_o;
    logic [NUM_MASTERS-1:0]       m_rty_o;

    logic [31:0] wb_ext_adr_i;
    logic [31:0] wb_ext_dat_i;
    logic [3:0]  wb_ext_sel_i;
    logic [2:0]  wb_ext_cti_i;
    logic [1:0]  wb_ext_bte_i;
    logic        wb_ext_cyc_i;
    logic        wb_ext_stb_i;
    logic        wb_ext_we_i;
    logic        wb_ext_cab_i;
    logic [31:0] wb_ext_dat_o;
    logic        wb_ext_ack_o;
    logic        wb_ext_err_o;
    logic        wb_ext_rty_o;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
        input  m_cyc_i, m_stb_i, m_we_i, m_cab_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output wb_ext_adr_i, wb_ext_dat_i, wb_ext_sel_i, wb_ext_cti_i, wb_ext_bte_i,
        output wb_ext_cyc_i, wb_ext_stb_i, wb_ext_we_i, wb_ext_cab_i,
        input  wb_ext_dat_o, wb_ext_ack_o, wb_ext_err_o, wb_ext_rty_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
        output m_cyc_i, m_stb_i, m_we_i, m_cab_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  wb_ext_adr_i, wb_ext_dat_i, wb_ext_sel_i, wb_ext_cti_i, wb_ext_bte_i,
        input  wb_ext_cyc_i, wb_ext_stb_i, wb_ext_we_i, wb_ext_cab_i,
        output wb_ext_dat_o, wb_ext_ack_o, wb_ext_err_o, wb_ext_rty_o
    );
endinterface

// File: rtl/mpsoc_wb_ext_arbiter.sv
// Round-robin arbiter of NUM_MASTERS Wishbone masters onto one external bus; grant after 1 cycle,
// owner keeps the bus until it drops cyc, a stalled strobe is aborted with err after TIMEOUT cycles.
module mpsoc_wb_ext_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    mpsoc_wb_ext_arbiter_if.slave   bus,
    output logic [NUM_MASTERS-1:0]  grant_o,
    output logic                    timeout_o
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic [IW-1:0]          sel;
    logic                   found;
    logic [IW-1:0]          gidx_inc;
    logic                   resp;
    logic                   own;
    logic                   abort;

    // First requester at or after the pointer, wrapping at NUM_MASTERS.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && bus.m_cyc_i[IW'((int'(ptr_q) + i) % NUM_MASTERS)]) begin
                sel   = IW'((int'(ptr_q) + i) % NUM_MASTERS);
                found = 1'b1;
            end
        end
    end

    assign gidx_inc = (gidx_q == IW'(NUM_MASTERS - 1)) ? '0 : gidx_q + IW'(1);
    assign resp     = bus.wb_ext_ack_o | bus.wb_ext_err_o | bus.wb_ext_rty_o;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = OWN;
                    gidx_d       = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    cnt_d        = '0;
                end
            end
            OWN: begin
                if (!bus.m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_inc;
                    cnt_d   = '0;
                end else if (resp || !bus.m_stb_i[gidx_q]) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    // A response in this same cycle would have taken the branch above.
                    if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
                        state_d   = ABORT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ABORT: begin
                cnt_d = '0;
                if (!bus.m_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_inc;
                end else begin
                    state_d = OWN;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign own   = (state_q == OWN);
    assign abort = (state_q == ABORT);

    assign bus.wb_ext_adr_i = bus.m_adr_i[gidx_q];
    assign bus.wb_ext_dat_i = bus.m_dat_i[gidx_q];
    assign bus.wb_ext_sel_i = bus.m_sel_i[gidx_q];
    assign bus.wb_ext_cti_i = bus.m_cti_i[gidx_q];
    assign bus.wb_ext_bte_i = bus.m_bte_i[gidx_q];
    assign bus.wb_ext_we_i  = bus.m_we_i[gidx_q];
    assign bus.wb_ext_cab_i = bus.m_cab_i[gidx_q];
    assign bus.wb_ext_cyc_i = own & bus.m_cyc_i[gidx_q];
    assign bus.wb_ext_stb_i = own & bus.m_stb_i[gidx_q];

    assign bus.m_dat_o = bus.wb_ext_dat_o;
    assign bus.m_ack_o = (own && bus.wb_ext_ack_o) ? grant_q : '0;
    assign bus.m_err_o = ((own && bus.wb_ext_err_o) || abort) ? grant_q : '0;
    assign bus.m_rty_o = (own && bus.wb_ext_rty_o) ? grant_q : '0;

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_mpsoc_wb_ext_arbiter.sv
// Directed bench for mpsoc_wb_ext_arbiter: 4 masters, TIMEOUT=8.
module tb_mpsoc_wb_ext_arbiter;
    logic       clk;
    logic       rst;
    logic [3:0] grant_o;
    logic       timeout_o;
    int         tests_run;
    int         tests_failed;

    mpsoc_wb_ext_arbiter_if #(.NUM_MASTERS(4)) bus ();

    mpsoc_wb_ext_arbiter #(.NUM_MASTERS(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            bus.m_adr_i[i] = 32'h1000_0000 * (i + 1);
            bus.m_dat_i[i] = 32'hD000_0000 + i;
            bus.m_sel_i[i] = 4'hF;
            bus.m_cti_i[i] = 3'b000;
            bus.m_bte_i[i] = 2'b00;
        end
        bus.m_cyc_i      = '0;
        bus.m_stb_i      = '0;
        bus.m_we_i       = '0;
        bus.m_cab_i      = '0;
        bus.wb_ext_dat_o = '0;
        bus.wb_ext_ack_o = 1'b0;
        bus.wb_ext_err_o = 1'b0;
        bus.wb_ext_rty_o = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.m_cyc_i = 4'b1111;
        bus.m_stb_i = 4'b1111;
        bus.wb_ext_ack_o = 1'b1;
        step();
        step();
        tests_run++; if (grant_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
        tests_run++; if (timeout_o !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
        tests_run++; if (bus.wb_ext_cyc_i !== 1'b0 || bus.wb_ext_stb_i !== 1'b0) begin tests_failed++; $display("FAIL reset_cyc_stb: got %b%b want 00", bus.wb_ext_cyc_i, bus.wb_ext_stb_i); end
        tests_run++; if (bus.m_ack_o !== 4'b0000 || bus.m_err_o !== 4'b0000 || bus.m_rty_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_resp: got ack %b err %b rty %b want 0", bus.m_ack_o, bus.m_err_o, bus.m_rty_o); end
        clear_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle_discard();
        bus.wb_ext_ack_o = 1'b1;
        bus.wb_ext_err_o = 1'b1;
        bus.wb_ext_dat_o = 32'hCAFE_F00D;
        #1;
        tests_run++; if (bus.m_ack_o !== 4'b0000 || bus.m_err_o !== 4'b0000) begin tests_failed++; $display("FAIL idle_discard: got ack %b err %b want 0000", bus.m_ack_o, bus.m_err_o); end
        tests_run++; if (bus.m_dat_o !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL dat_passthru: got %h want cafef00d", bus.m_dat_o); end
        step();
        tests_run++; if (grant_o !== 4'b0000 || bus.wb_ext_cyc_i !== 1'b0) begin tests_failed++; $display("FAIL idle_stays: got grant %b cyc %b want 0000 0", grant_o, bus.wb_ext_cyc_i); end
        clear_inputs();
    endtask

    task automatic test_two_masters();
        do_reset();
        bus.m_cyc_i = 4'b0101;
        #1;
        tests_run++; if (grant_o !== 4'b0000) begin tests_failed++; $display("FAIL two_pre_grant: got %b want 0000", grant_o); end
        step();
        tests_run++; if (grant_o !== 4'b0001) begin tests_failed++; $display("FAIL two_grant_m0: got %b want 0001", grant_o); end
        tests_run++; if (bus.wb_ext_cyc_i !== 1'b1 || bus.wb_ext_adr_i !== 32'h1000_0000) begin tests_failed++; $display("FAIL two_mirror_m0: got cyc %b adr %h want 1 10000000", bus.wb_ext_cyc_i, bus.wb_ext_adr_i); end
        bus.m_cyc_i[0] = 1'b0;
        step();
        tests_run++; if (grant_o !== 4'b0000 || bus.wb_ext_cyc_i !== 1'b0) begin tests_failed++; $display("FAIL two_idle_gap: got grant %b cyc %b want 0000 0", grant_o, bus.wb_ext_cyc_i); end
        step();
        tests_run++; if (grant_o !== 4'b0100) begin tests_failed++; $display("FAIL two_grant_m2: got %b want 0100", grant_o); end
        tests_run++; if (bus.wb_ext_adr_i !== 32'h3000_0000) begin tests_failed++; $display("FAIL two_mirror_m2: got %h want 30000000", bus.wb_ext_adr_i); end
        bus.m_cyc_i[2] = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        bus.m_cyc_i = 4'b1111;
        bus.m_stb_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            tests_run++; if (grant_o !== (4'b0001 << exp_order[k])) begin tests_failed++; $display("FAIL rr_grant_%0d: got %b want %b", k, grant_o, 4'b0001 << exp_order[k]); end
            bus.wb_ext_ack_o = 1'b1;
            #1;
            tests_run++; if (bus.m_ack_o !== (4'b0001 << exp_order[k])) begin tests_failed++; $display("FAIL rr_ack_%0d: got %b want %b", k, bus.m_ack_o, 4'b0001 << exp_order[k]); end
            step();
            bus.wb_ext_ack_o = 1'b0;
            bus.m_cyc_i[exp_order[k]] = 1'b0;
            bus.m_stb_i[exp_order[k]] = 1'b0;
            step();
            tests_run++; if (grant_o !== 4'b0000) begin tests_failed++; $display("FAIL rr_release_%0d: got %b want 0000", k, grant_o); end
            if (k == 0) begin
                bus.m_cyc_i[0] = 1'b1;
                bus.m_stb_i[0] = 1'b1;
            end
        end
        clear_inputs();
    endtask

    task automatic test_burst();
        int acks;
        acks = 0;
        bus.m_cyc_i[1] = 1'b1;
        bus.m_stb_i[1] = 1'b1;
        bus.m_cti_i[1] = 3'b010;
        step();
        tests_run++; if (grant_o !== 4'b0010) begin tests_failed++; $display("FAIL burst_grant: got %b want 0010", grant_o); end
        bus.m_cyc_i[3] = 1'b1;
        bus.m_stb_i[3] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.m_cti_i[1] = (b == 3) ? 3'b111 : 3'b010;
            bus.m_adr_i[1] = 32'h0000_0100 + 4 * b;
            #1;
            tests_run++; if (grant_o !== 4'b0010 || bus.m_ack_o !== 4'b0000) begin tests_failed++; $display("FAIL burst_wait_%0d: got grant %b ack %b want 0010 0000", b, grant_o, bus.m_ack_o); end
            step();
            bus.wb_ext_ack_o = 1'b1;
            #1;
            if (bus.m_ack_o == 4'b0010) acks++;
            tests_run++; if (bus.m_ack_o !== 4'b0010 || bus.wb_ext_adr_i !== 32'h0000_0100 + 4 * b) begin tests_failed++; $display("FAIL burst_beat_%0d: got ack %b adr %h want 0010 %h", b, bus.m_ack_o, bus.wb_ext_adr_i, 32'h0000_0100 + 4 * b); end
            step();
            bus.wb_ext_ack_o = 1'b0;
        end
        tests_run++; if (acks !== 4) begin tests_failed++; $display("FAIL burst_ack_count: got %0d want 4", acks); end
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        step();
        tests_run++; if (grant_o !== 4'b0000) begin tests_failed++; $display("FAIL burst_release: got %b want 0000", grant_o); end
        step();
        tests_run++; if (grant_o !== 4'b1000) begin tests_failed++; $display("FAIL burst_m3_after: got %b want 1000", grant_o); end
        bus.m_cyc_i[3] = 1'b0;
        bus.m_stb_i[3] = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_timeout();
        bus.m_cyc_i[2] = 1'b1;
        bus.m_stb_i[2] = 1'b1;
        step();
        tests_run++; if (grant_o !== 4'b0100) begin tests_failed++; $display("FAIL to_grant: got %b want 0100", grant_o); end
        for (int k = 1; k <= 8; k++) begin
            tests_run++; if (bus.wb_ext_cyc_i !== 1'b1 || bus.m_err_o !== 4'b0000 || timeout_o !== 1'b0) begin tests_failed++; $display("FAIL to_wait_%0d: got cyc %b err %b to %b want 1 0000 0", k, bus.wb_ext_cyc_i, bus.m_err_o, timeout_o); end
            step();
        end
        tests_run++; if (bus.wb_ext_cyc_i !== 1'b0 || bus.wb_ext_stb_i !== 1'b0) begin tests_failed++; $display("FAIL to_abort_bus: got cyc %b stb %b want 0 0", bus.wb_ext_cyc_i, bus.wb_ext_stb_i); end
        tests_run++; if (bus.m_err_o !== 4'b0100 || timeout_o !== 1'b1) begin tests_failed++; $display("FAIL to_abort_err: got err %b to %b want 0100 1", bus.m_err_o, timeout_o); end
        bus.m_cyc_i[2] = 1'b0;
        bus.m_stb_i[2] = 1'b0;
        step();
        tests_run++; if (grant_o !== 4'b0000 || timeout_o !== 1'b0 || bus.m_err_o !== 4'b0000) begin tests_failed++; $display("FAIL to_idle: got grant %b to %b err %b want 0000 0 0000", grant_o, timeout_o, bus.m_err_o); end
        clear_inputs();
    endtask

    task automatic test_ack_on_last();
        bus.m_cyc_i[1] = 1'b1;
        bus.m_stb_i[1] = 1'b1;
        step();
        for (int k = 1; k <= 7; k++) step();
        bus.wb_ext_ack_o = 1'b1;
        #1;
        tests_run++; if (bus.m_ack_o !== 4'b0010 || bus.m_err_o !== 4'b0000) begin tests_failed++; $display("FAIL last_ack: got ack %b err %b want 0010 0000", bus.m_ack_o, bus.m_err_o); end
        step();
        bus.wb_ext_ack_o = 1'b0;
        #1;
        tests_run++; if (bus.wb_ext_cyc_i !== 1'b1 || timeout_o !== 1'b0 || bus.m_err_o !== 4'b0000) begin tests_failed++; $display("FAIL last_no_abort: got cyc %b to %b err %b want 1 0 0000", bus.wb_ext_cyc_i, timeout_o, bus.m_err_o); end
        for (int k = 1; k <= 7; k++) step();
        tests_run++; if (bus.wb_ext_cyc_i !== 1'b1 || timeout_o !== 1'b0) begin tests_failed++; $display("FAIL last_restart: got cyc %b to %b want 1 0", bus.wb_ext_cyc_i, timeout_o); end
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        step();
        bus.m_cyc_i[1] = 1'b1;
        step();
        tests_run++; if (grant_o !== 4'b0010) begin tests_failed++; $display("FAIL self_regrant: got %b want 0010", grant_o); end
        bus.m_cyc_i[1] = 1'b0;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bus.m_cyc_i[1] = 1'b1;
        bus.m_stb_i[1] = 1'b1;
        bus.m_cti_i[1] = 3'b010;
        step();
        step();
        bus.wb_ext_ack_o = 1'b1;
        #1;
        tests_run++; if (bus.m_ack_o !== 4'b0010) begin tests_failed++; $display("FAIL mid_pre_ack: got %b want 0010", bus.m_ack_o); end
        #1;
        rst = 1'b1;
        #1;
        tests_run++; if (grant_o !== 4'b0000 || bus.wb_ext_cyc_i !== 1'b0 || bus.wb_ext_stb_i !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_bus: got grant %b cyc %b stb %b want 0000 0 0", grant_o, bus.wb_ext_cyc_i, bus.wb_ext_stb_i); end
        tests_run++; if (bus.m_ack_o !== 4'b0000 || timeout_o !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_resp: got ack %b to %b want 0000 0", bus.m_ack_o, timeout_o); end
        clear_inputs();
        bus.m_cyc_i[3] = 1'b1;
        bus.m_stb_i[3] = 1'b1;
        step();
        rst = 1'b0;
        step();
        tests_run++; if (grant_o !== 4'b1000) begin tests_failed++; $display("FAIL mid_m3_grant: got %b want 1000", grant_o); end
        bus.m_cyc_i[3] = 1'b0;
        step();
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear_inputs();
        test_reset();
        test_idle_discard();
        test_two_masters();
        test_round_robin();
        test_burst();
        test_timeout();
        test_ack_on_last();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mpsoc_wb_ext_arbiter.md
MPSOC_WB_EXT_ARBITER -- requirements
Module: mpsoc_wb_ext_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, bus cycles without ack/err/rty before abort (1..65535).
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: m_adr_i/m_dat_i  in  NUM_MASTERS x 32  per-master address/write data.
REQ-006 SHALL have ports: m_sel_i  in  NUM_MASTERS x 4; m_cti_i  in  NUM_MASTERS x 3; m_bte_i  in  NUM_MASTERS x 2.
REQ-007 SHALL have ports: m_cyc_i/m_stb_i/m_we_i/m_cab_i  in  NUM_MASTERS  per-master strobes.
REQ-008 SHALL have ports: m_dat_o  out  32  shared read data; m_ack_o/m_err_o/m_rty_o  out  NUM_MASTERS.
REQ-009 SHALL have ports: wb_ext_adr_i/dat_i  out  32; sel_i  out  4; cti_i  out  3; bte_i  out  2; cyc_i/stb_i/we_i/cab_i  out  1 (external bus, names as on the system top).
REQ-010 SHALL have ports: wb_ext_dat_o  in  32; wb_ext_ack_o/err_o/rty_o  in  1  external slave responses.
REQ-011 SHALL have ports: grant_o  out  NUM_MASTERS  one-hot current owner; timeout_o  out  1  abort pulse.

Function
REQ-012 SHALL implement FSM states IDLE, OWN, ABORT.
REQ-013 IDLE: when any m_cyc_i high, SHALL register grant to first requester at or after round-robin pointer (wrapping NUM_MASTERS-1 -> 0) and enter OWN next cycle; grant latency exactly 1 cycle.
REQ-014 IDLE: wb_ext_cyc_i/stb_i SHALL be 0; no m_ack/err/rty asserted.
REQ-015 OWN: all wb_ext_* outputs SHALL combinationally mirror the granted master's signals; granted master's m_ack/err/rty SHALL mirror wb_ext_ack/err/rty; all other masters' responses SHALL be 0.
REQ-016 OWN: grant SHALL be held while granted m_cyc_i high, including across cti bursts and stb gaps; no preemption.
REQ-017 OWN -> IDLE when granted m_cyc_i low; pointer SHALL become granted index+1 (mod NUM_MASTERS); grant_o cleared same edge.
REQ-018 Requests from other masters during OWN SHALL be ignored until IDLE; a master dropping cyc before grant SHALL lose its request with no response.
REQ-019 Watchdog: 16-bit counter SHALL clear on entering OWN, on any wb_ext_ack/err/rty, and whenever granted stb low; SHALL increment each OWN cycle with stb high and no response.
REQ-020 Counter reaching TIMEOUT SHALL force transition to ABORT.
REQ-021 ABORT (exactly 1 cycle): wb_ext_cyc_i/stb_i forced 0; granted m_err_o=1 and timeout_o=1 for that cycle; then OWN if granted cyc still high, else IDLE (pointer advanced).
REQ-022 Slave response arriving in the same cycle as counter reaching TIMEOUT SHALL take priority: response forwarded, no ABORT.
REQ-023 m_dat_o SHALL always equal wb_ext_dat_o.
REQ-024 Single requester SHALL be regranted after 1 IDLE cycle (no starvation of self).
REQ-025 Ack/err/rty received while not in OWN SHALL be discarded.

Reset
REQ-026 rst high SHALL immediately force IDLE, grant_o=0, pointer=0, counter=0, timeout_o=0, wb_ext_cyc_i/stb_i=0, all m_ack/err/rty=0, regardless of clk.
REQ-027 Reset mid-transfer SHALL drop the bus cycle with no response to the master; first grant after release SHALL follow REQ-013 with pointer 0.

Verification
REQ-028 Masters 0,2 assert cyc same cycle after reset -> grant_o=0001 one cycle later; after M0 drops cyc, IDLE 1 cycle, then grant_o=0100.
REQ-029 All 4 masters hold cyc continuously, each releasing after 1 ack -> grants in order 0,1,2,3,0; never two bits set.
REQ-030 M1 4-beat burst (cti=010..111), slave acks every other cycle -> 4 acks to M1 only, grant held throughout, M3 request waits.
REQ-031 TIMEOUT=8, slave never acks M2 read -> after 8 stb cycles wb_ext_cyc_i=0 one cycle, m_err_o[2]=1, timeout_o=1; then IDLE if cyc dropped.
REQ-032 TIMEOUT=8, ack arrives on 8th wait cycle -> m_ack_o=1, no err, no timeout_o.
REQ-033 rst asserted mid-burst between clk edges -> outputs zero immediately; after release M3 alone requesting -> granted next cycle.
